// File: rtl/poly_ctrl_pkg.sv
// poly_ctrl_pkg: shared opcodes, butterfly modes and controller state for the polynomial multiplier.
package poly_ctrl_pkg;
    localparam logic [2:0] CONF_NTT  = 3'd1;
    localparam logic [2:0] CONF_INTT = 3'd2;
    localparam logic [2:0] CONF_PWM  = 3'd3;
    localparam logic [2:0] CONF_ACK  = 3'd4;
    localparam logic [1:0] BF_CT  = 2'd0;
    localparam logic [1:0] BF_GS  = 2'd1;
    localparam logic [1:0] BF_PWM = 2'd2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic logic is_op(input logic [2:0] c);
        return c == CONF_NTT || c == CONF_INTT || c == CONF_PWM;
    endfunction
    function automatic logic [1:0] op_mode(input logic [2:0] c);
        return c == CONF_NTT ? BF_CT : c == CONF_INTT ? BF_GS : BF_PWM;
    endfunction
    function automatic logic [2:0] op_onehot(input logic [2:0] c);
        return 3'b001 << (c - 3'd1);
    endfunction
endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: maps (stage, butterfly index, op) to operand and twiddle addresses.
module ntt_addr_gen
    import poly_ctrl_pkg::*;
#(
    parameter int N    = 512,
    parameter int LOGN = 9,
    parameter int SW   = 4
) (
    input  logic [SW-1:0]   s,
    input  logic [LOGN-1:0] k,
    input  logic [2:0]      op,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN:0]   tw_addr
);
    localparam logic [LOGN:0] N_W  = (LOGN+1)'(N);
    localparam logic [LOGN:0] NH_W = (LOGN+1)'(N / 2);
    logic            intt, pwm;
    logic [SW-1:0]   sh;
    logic [LOGN-1:0] len, g, j, a;
    always_comb begin
        intt = op == CONF_INTT;
        pwm  = op == CONF_PWM;
        // sh = log2(len): shrinking spans for CT, growing spans for GS
        sh   = intt ? s : SW'(LOGN - 1) - s;
        len  = LOGN'(1) << sh;
        g    = k >> sh;
        j    = k & (len - 1'b1);
        a    = ((g << sh) << 1) + j;
        addr_a  = pwm ? k : a;
        addr_b  = pwm ? k : a + len;
        tw_addr = pwm ? '0 : intt ? N_W + (NH_W >> s) + {1'b0, g} : ((LOGN+1)'(1) << s) + {1'b0, g};
    end
endmodule

// File: rtl/poly_mul_ctrl.sv
// poly_mul_ctrl: sequences NTT / INTT / PWM over ping-pong banks with a BF_LAT write delay line.
module poly_mul_ctrl
    import poly_ctrl_pkg::*;
#(
    parameter int N      = 512,
    parameter int LOGN   = 9,
    parameter int BF_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      conf,
    output logic [2:0]      done_flag,
    output logic            rd_en,
    output logic            rd_bank,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN:0]   tw_addr,
    output logic [1:0]      bf_mode,
    output logic            wr_en,
    output logic            wr_bank,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);
    localparam int SW = $clog2(LOGN + 1);
    localparam int CW = $clog2(BF_LAT + 1);
    localparam logic [LOGN-1:0] K_HALF = LOGN'(N / 2 - 1);
    localparam logic [LOGN-1:0] K_FULL = LOGN'(N - 1);
    localparam logic [SW-1:0]   S_LAST = SW'(LOGN - 1);
    localparam logic [CW-1:0]   C_LAST = CW'(BF_LAT - 1);
    state_t          state;
    logic [2:0]      op;
    logic [SW-1:0]   s;
    logic [LOGN-1:0] k, ga, gb;
    logic [CW-1:0]   cnt;
    logic [LOGN:0]   gt;
    logic            pwm;
    logic [2*LOGN+1:0] dly [BF_LAT];
    assign pwm = op == CONF_PWM;
    ntt_addr_gen #(.N(N), .LOGN(LOGN), .SW(SW)) u_gen (
        .s(s), .k(k), .op(op), .addr_a(ga), .addr_b(gb), .tw_addr(gt)
    );
    assign rd_addr_a = rd_en ? ga : '0;
    assign rd_addr_b = rd_en ? gb : '0;
    assign tw_addr   = rd_en ? gt : '0;
    assign rd_bank   = rd_en & ~pwm & s[0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= '0;
            s         <= '0;
            k         <= '0;
            cnt       <= '0;
            rd_en     <= 1'b0;
            bf_mode   <= '0;
            done_flag <= '0;
        end else begin
            case (state)
                IDLE: if (is_op(conf)) begin
                    op      <= conf;
                    s       <= '0;
                    k       <= '0;
                    rd_en   <= 1'b1;
                    bf_mode <= op_mode(conf);
                    state   <= RUN;
                end
                RUN: if (k == (pwm ? K_FULL : K_HALF)) begin
                    k     <= '0;
                    cnt   <= '0;
                    rd_en <= 1'b0;
                    state <= DRAIN;
                end else begin
                    k <= k + 1'b1;
                end
                DRAIN: if (cnt != C_LAST) begin
                    cnt <= cnt + 1'b1;
                end else if (!pwm && s != S_LAST) begin
                    s     <= s + 1'b1;
                    rd_en <= 1'b1;
                    state <= RUN;
                end else begin
                    done_flag <= op_onehot(op);
                    state     <= DONE;
                end
                DONE: if (conf != op) begin
                    done_flag <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // each read's write tuple emerges exactly BF_LAT cycles later; reset drops in-flight writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {rd_en, rd_en & ~pwm & ~s[0], rd_addr_a, rd_addr_b};
            for (int i = 1; i < BF_LAT; i++) dly[i] <= dly[i-1];
        end
    end
    assign {wr_en, wr_bank, wr_addr_a, wr_addr_b} = dly[BF_LAT-1];
endmodule

// File: tb/tb_poly_mul_ctrl.sv
// tb_poly_mul_ctrl: directed table-driven bench for poly_mul_ctrl at N=8, LOGN=3, BF_LAT=2.
module tb_poly_mul_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] conf;
    logic [2:0] done_flag;
    logic       rd_en, rd_bank, wr_en, wr_bank;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [3:0] tw_addr;
    logic [1:0] bf_mode;
    int errors = 0;
    int checks = 0;

    poly_mul_ctrl #(.N(8), .LOGN(3), .BF_LAT(2)) dut (
        .clk(clk), .rst(rst), .conf(conf), .done_flag(done_flag),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_addr(tw_addr), .bf_mode(bf_mode), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        int         cyc;
        logic [2:0] a, b;
        logic [3:0] tw;
        logic       bank;
    } vec_t;

    typedef struct {
        logic       rd_en, rd_bank, wr_en, wr_bank;
        logic [2:0] ra, rb, wa, wb, done;
        logic [3:0] tw;
        logic [1:0] mode;
    } smp_t;

    vec_t vq[$];
    smp_t tr [0:19];

    task automatic add(input logic [2:0] op, input int cyc, input logic [2:0] a, input logic [2:0] b,
                       input logic [3:0] tw, input logic bank);
        vec_t v;
        v.op = op; v.cyc = cyc; v.a = a; v.b = b; v.tw = tw; v.bank = bank;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic smp_t samp();
        smp_t t;
        t.rd_en = rd_en; t.rd_bank = rd_bank; t.ra = rd_addr_a; t.rb = rd_addr_b; t.tw = tw_addr;
        t.mode = bf_mode; t.wr_en = wr_en; t.wr_bank = wr_bank; t.wa = wr_addr_a; t.wb = wr_addr_b;
        t.done = done_flag;
        return t;
    endfunction

    task automatic chk_idle_outputs(input string nm);
        chk(nm, {rd_en, rd_bank, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_bank, wr_addr_a, wr_addr_b, done_flag}, 0);
    endtask

    // starts an op at the next edge (block must be idle) and checks the whole run up to done
    task automatic run(input logic [2:0] op, input int chg, input logic [2:0] cv);
        int nd, nr, nw;
        smp_t p;
        nd = (op == 3'd3) ? 11 : 19;
        nr = 0;
        nw = 0;
        for (int c = 0; c < 20; c++) tr[c] = '{default: '0};
        conf = op;
        @(posedge clk);
        for (int c = 1; c <= nd; c++) begin
            @(negedge clk);
            tr[c] = samp();
            if (c == chg) conf = cv;
        end
        foreach (vq[i]) if (vq[i].op == op) begin
            chk($sformatf("rd op%0d cyc%0d", op, vq[i].cyc),
                {tr[vq[i].cyc].rd_en, tr[vq[i].cyc].rd_bank, tr[vq[i].cyc].ra, tr[vq[i].cyc].rb, tr[vq[i].cyc].tw},
                {1'b1, vq[i].bank, vq[i].a, vq[i].b, vq[i].tw});
        end
        for (int c = 1; c <= nd; c++) begin
            if (tr[c].rd_en) nr++;
            if (tr[c].wr_en) begin
                nw++;
                p = tr[c > 2 ? c - 2 : 0];
                chk($sformatf("wr op%0d cyc%0d", op, c), {tr[c].wr_en, tr[c].wr_bank, tr[c].wa, tr[c].wb},
                    {p.rd_en, (op == 3'd3) ? 1'b0 : ~p.rd_bank, p.ra, p.rb});
            end
        end
        chk($sformatf("rd count op%0d", op), nr, (op == 3'd3) ? 8 : 12);
        chk($sformatf("wr count op%0d", op), nw, (op == 3'd3) ? 8 : 12);
        chk($sformatf("mode op%0d", op), tr[1].mode, (op == 3'd1) ? 0 : (op == 3'd2) ? 1 : 2);
        chk($sformatf("done early op%0d", op), tr[nd-1].done, 0);
        chk($sformatf("done op%0d", op), tr[nd].done, (op == 3'd1) ? 3'b001 : (op == 3'd2) ? 3'b010 : 3'b100);
    endtask

    task automatic ack();
        conf = 3'd4;
        @(negedge clk);
        chk("done clear", done_flag, 0);
    endtask

    initial begin
        add(1, 1, 0, 4, 1, 0);  add(1, 2, 1, 5, 1, 0);  add(1, 3, 2, 6, 1, 0);  add(1, 4, 3, 7, 1, 0);
        add(1, 7, 0, 2, 2, 1);  add(1, 8, 1, 3, 2, 1);  add(1, 9, 4, 6, 3, 1);  add(1, 10, 5, 7, 3, 1);
        add(1, 13, 0, 1, 4, 0); add(1, 14, 2, 3, 5, 0); add(1, 15, 4, 5, 6, 0); add(1, 16, 6, 7, 7, 0);
        add(2, 1, 0, 1, 12, 0); add(2, 2, 2, 3, 13, 0); add(2, 3, 4, 5, 14, 0); add(2, 4, 6, 7, 15, 0);
        add(2, 7, 0, 2, 10, 1); add(2, 8, 1, 3, 10, 1); add(2, 9, 4, 6, 11, 1); add(2, 10, 5, 7, 11, 1);
        add(2, 13, 0, 4, 9, 0); add(2, 14, 1, 5, 9, 0); add(2, 15, 2, 6, 9, 0); add(2, 16, 3, 7, 9, 0);
        for (int k = 0; k < 8; k++) add(3, k + 1, 3'(k), 3'(k), 0, 0);

        rst = 1'b1;
        conf = 3'd0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset outputs");
        chk("reset mode", bf_mode, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("idle conf0");

        run(3'd1, 0, 3'd0); ack();
        run(3'd2, 0, 3'd0); ack();
        run(3'd3, 0, 3'd0); ack();

        // conf change mid-op is ignored; the still-held INTT code then releases DONE and starts INTT
        run(3'd1, 5, 3'd2);
        @(negedge clk);
        chk("done clear on conf change", done_flag, 0);
        run(3'd2, 0, 3'd0); ack();

        // asynchronous reset in cycle 8 of an NTT, then restart with conf still held
        conf = 3'd1;
        @(posedge clk);
        repeat (8) @(negedge clk);
        chk("pre-reset rd_en", rd_en, 1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("async reset outputs");
        @(negedge clk);
        chk_idle_outputs("held reset outputs");
        rst = 1'b0;
        run(3'd1, 0, 3'd0); ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/poly_mul_ctrl.md
# poly_mul_ctrl

Operation controller for the radix-2 polynomial multiplier. It accepts a level-held 3-bit operation code `conf` and sequences forward NTT, inverse NTT or point-wise multiply over the two ping-pong coefficient banks (`bank_0`, `bank_1`). It drives bank addresses, twiddle addresses and butterfly mode, and reports completion on a one-hot `done_flag`. It sits inside `top_poly_mul` as the responder to the host/testbench that drives `conf`.

## Interface
- `N`, 512: polynomial length, power of two.
- `LOGN`, 9: log2(N).
- `BF_LAT`, 4: butterfly pipeline latency in cycles, read-issue to write.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `conf` in 3: operation code. 1 = NTT, 2 = INTT, 3 = PWM; 0 and 4..7 = idle/acknowledge.
- `done_flag` out 3: one-hot completion. bit0 = NTT, bit1 = INTT, bit2 = PWM.
- `rd_en` out 1: read address valid.
- `rd_bank` out 1: source bank for reads (0 = bank_0).
- `rd_addr_a`, `rd_addr_b` out LOGN: butterfly operand addresses.
- `tw_addr` out LOGN+1: twiddle ROM address.
- `bf_mode` out 2: 0 = CT (NTT), 1 = GS (INTT), 2 = PWM, 3 = unused.
- `wr_en` out 1: write enable.
- `wr_bank` out 1: destination bank.
- `wr_addr_a`, `wr_addr_b` out LOGN: write addresses.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: if `conf` is 1, 2 or 3 at a clock edge, latch the op and go to RUN with stage `s` = 0 and index `k` = 0. Other codes keep IDLE.
- RUN (NTT/INTT): `k` runs 0..N/2-1, one butterfly per cycle, `rd_en` = 1.
- DRAIN: BF_LAT cycles with `rd_en` = 0. Afterwards, if `s` < LOGN-1, increment `s` and return to RUN; otherwise go to DONE.
- Forward NTT, stage `s`: len = N>>(s+1), g = k>>log2(len), j = k&(len-1), a = 2·g·len + j, b = a + len, tw = (1<<s) + g.
- INTT, stage `s`: len = 1<<s, same a/b formula, tw = N + (N>>(s+1)) + g.
- Ping-pong: stage `s` reads bank `s`%2 and writes bank (`s`+1)%2. The final result is in bank LOGN%2 (bank_1 for N=512).
- PWM: a single RUN of N cycles with `k` = 0..N-1. rd_addr_a = rd_addr_b = k. `rd_bank` = 0 (the datapath reads both banks). Writes go to bank_0. `tw_addr` = 0. Then DRAIN, then DONE.
- Write path: {`wr_en`, `wr_bank`, `wr_addr_a`, `wr_addr_b`} is the read-side tuple delayed by exactly BF_LAT cycles.
- DONE: `done_flag` = one-hot of the latched op, held while `conf` equals the latched op. When `conf` differs, clear `done_flag` and go to IDLE on the next edge.
- `conf` changes during RUN/DRAIN are ignored.
- Address arithmetic is unsigned, with no wrap. All addresses stay below N (tw below 2N).

## Timing
- Reset: all outputs 0 and state IDLE. The write delay line is cleared, so in-flight writes are dropped. This also applies to reset asserted mid-operation.
- Let E0 be the edge that samples a valid `conf` in IDLE. Cycle 1 (after E0) issues `k` = 0.
- NTT/INTT:
  - Stage `s` reads in cycles `s`·(N/2+BF_LAT)+1 through `s`·(N/2+BF_LAT)+N/2.
  - The last write of a stage occurs in the cycle immediately before the next stage's first read, so read-after-write holds with synchronous-write banks.
  - `done_flag` goes high in cycle LOGN·(N/2+BF_LAT)+1.
- PWM: `done_flag` goes high in cycle N+BF_LAT+1.
- `done_flag` deasserts one cycle after the edge that samples `conf` ≠ the latched op.
- A new op can start on the edge after return to IDLE. Throughput is one butterfly per cycle.

## Structure
- Shared package `poly_ctrl_pkg` holds:
  - `conf` codes (CONF_NTT = 1, CONF_INTT = 2, CONF_PWM = 3, CONF_ACK = 4);
  - `bf_mode` encodings;
  - the state enum.
- Sub-module `ntt_addr_gen` is combinational: (s, k, op) -> rd_addr_a/b, tw_addr.
- The FSM, counters and BF_LAT delay line stay in `poly_mul_ctrl`.

## Test plan
- N=8, LOGN=3, BF_LAT=2, conf=1 held, then set to 4 on done:
  - stage 0 pairs (0,4),(1,5),(2,6),(3,7), tw 1,1,1,1;
  - stage 2 pairs (0,1),(2,3),(4,5),(6,7), tw 4,5,6,7;
  - `done_flag` = 3'b001 at cycle 19, then 0 the cycle after conf=4 is sampled.
- Same parameters, conf=2:
  - stage 0 pairs (0,1)… with tw 12,13,14,15;
  - stage 2 pairs (0,4)… with tw 9;
  - `done_flag` = 3'b010 at cycle 19.
- conf=3: k = 0..7 with `bf_mode` = 2; wr_en pulses match rd_en delayed 2 cycles; `done_flag` = 3'b100 at cycle 11.
- Ping-pong and delay check: for every write, `wr_bank` = `rd_bank`^1 and `wr_addr` equals `rd_addr` from exactly BF_LAT cycles earlier. No read of a bank occurs before that bank's final write of the previous stage.
- conf 1 -> 2 at cycle 5: the op stays NTT and completes with `done_flag` = 3'b001. After done, conf=2 is still held and ≠ 1, so the block returns to IDLE and then starts INTT.
- rst pulse at cycle 8 of an NTT: all outputs 0 immediately, no `wr_en` afterwards. With conf=1 held, the op restarts from `s`=0, `k`=0 after rst falls.
